// File: rtl/para_seq.sv
// Measurement-window sequencer: frames sm_vld into windows and strobes the parameter engines.
// Optional RUN-state idle timeout is built when PARA_SEQ_TMO_EN is defined.
module para_seq #(
    parameter int CNT_W   = 16,
    parameter int SEQ_W   = 8,
    parameter int TMO_CYC = 4096
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_win_len,
    input  logic             cfg_cont,
    input  logic [7:0]       cfg_gap,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic             sta_clr,
    input  logic             sm_vld,
    output logic             para_clr,
    output logic             para_en,
    output logic             para_done,
    output logic [SEQ_W-1:0] win_seq,
    output logic [CNT_W-1:0] smp_cnt,
    output logic             busy,
    output logic             ovr,
    output logic             tmo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DONE,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] win_len;
    logic             cont;
    logic [7:0]       gap;
    logic [7:0]       gap_cnt;
    logic             stop_req;
    logic             last_smp;
    logic             tmo_hit;

    assign last_smp  = (state == S_RUN) && sm_vld
                       && (smp_cnt == win_len - CNT_W'(1));
    assign para_clr  = (state == S_CLR);
    assign para_en   = (state == S_RUN) && sm_vld;
    assign para_done = (state == S_DONE);
    assign busy      = (state != S_IDLE);

`ifdef PARA_SEQ_TMO_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] idle_cnt;
    logic             tmo_q;

    assign tmo_hit = (state == S_RUN) && !sm_vld
                     && (idle_cnt == TMO_W'(TMO_CYC - 1));
    assign tmo     = tmo_q;

    // Idle count restarts on every sample and whenever RUN is (re)entered
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            tmo_q    <= 1'b0;
        end else begin
            if (state != S_RUN || sm_vld)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + TMO_W'(1);
            if (tmo_hit)
                tmo_q <= 1'b1;
            else if (sta_clr)
                tmo_q <= 1'b0;
        end
    end
`else
    logic unused_tmo_cyc;

    assign unused_tmo_cyc = (TMO_CYC != 0);
    assign tmo_hit        = 1'b0;
    assign tmo            = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_start && !cmd_stop)
                    state_nxt = S_CLR;
            end
            S_CLR: begin
                state_nxt = cmd_stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (last_smp)
                    state_nxt = S_DONE;
                else if (cmd_stop || tmo_hit)
                    state_nxt = S_IDLE;
            end
            S_DONE: begin
                if (stop_req || cmd_stop || !cont)
                    state_nxt = S_IDLE;
                else if (gap == 8'd0)
                    state_nxt = S_CLR;
                else
                    state_nxt = S_GAP;
            end
            S_GAP: begin
                if (cmd_stop)
                    state_nxt = S_IDLE;
                else if (gap_cnt <= 8'd1)
                    state_nxt = S_CLR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            win_len  <= '0;
            cont     <= 1'b0;
            gap      <= '0;
            gap_cnt  <= '0;
            stop_req <= 1'b0;
            smp_cnt  <= '0;
            win_seq  <= '0;
        end else begin
            unique case (state)
                S_CLR: begin
                    smp_cnt <= '0;
                    win_len <= (cfg_win_len == '0) ? CNT_W'(1) : cfg_win_len;
                    cont    <= cfg_cont;
                    gap     <= cfg_gap;
                end
                S_RUN: begin
                    if (sm_vld)
                        smp_cnt <= smp_cnt + CNT_W'(1);
                    // A stop on the final sample still completes the window
                    if (last_smp && cmd_stop)
                        stop_req <= 1'b1;
                end
                S_DONE: begin
                    win_seq  <= win_seq + SEQ_W'(1);
                    gap_cnt  <= gap;
                    stop_req <= 1'b0;
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Set wins over a simultaneous clear
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst)
            ovr <= 1'b0;
        else if (cmd_start && busy)
            ovr <= 1'b1;
        else if (sta_clr)
            ovr <= 1'b0;
    end

endmodule

// File: tb/tb_para_seq.sv
// Directed bench for para_seq: window framing, continuous gaps, abort, overrun, wrap, timeout.
module tb_para_seq;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [15:0] cfg_win_len;
    logic        cfg_cont;
    logic [7:0]  cfg_gap;
    logic        cmd_start;
    logic        cmd_stop;
    logic        sta_clr;
    logic        sm_vld;
    logic        para_clr;
    logic        para_en;
    logic        para_done;
    logic [7:0]  win_seq;
    logic [15:0] smp_cnt;
    logic        busy;
    logic        ovr;
    logic        tmo;

    int total = 0;
    int bad   = 0;
    int n_clr = 0;
    int n_en  = 0;
    int n_done = 0;
    int seq   = 0;

    para_seq #(
        .CNT_W(16),
        .SEQ_W(8),
        .TMO_CYC(16)
    ) dut (
        .clk_sys(clk_sys),
        .rst(rst),
        .cfg_win_len(cfg_win_len),
        .cfg_cont(cfg_cont),
        .cfg_gap(cfg_gap),
        .cmd_start(cmd_start),
        .cmd_stop(cmd_stop),
        .sta_clr(sta_clr),
        .sm_vld(sm_vld),
        .para_clr(para_clr),
        .para_en(para_en),
        .para_done(para_done),
        .win_seq(win_seq),
        .smp_cnt(smp_cnt),
        .busy(busy),
        .ovr(ovr),
        .tmo(tmo)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        n_clr  = 0;
        n_en   = 0;
        n_done = 0;
    endtask

    // Inputs change on the falling edge; this cycle's outputs are observed 1ns later
    task automatic step(input logic st, input logic sp, input logic sc,
                        input logic v);
        logic ex;
        @(negedge clk_sys);
        cmd_start = st;
        cmd_stop  = sp;
        sta_clr   = sc;
        sm_vld    = v;
        #1;
        n_clr  += int'(para_clr);
        n_en   += int'(para_en);
        n_done += int'(para_done);
        ex = (para_clr & para_en) | (para_clr & para_done)
             | (para_en & para_done);
        chk("strobe_excl", 32'(ex), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cfg_win_len = 16'd4;
        cfg_cont = 1'b0;
        cfg_gap = 8'd0;
        cmd_start = 1'b1;
        cmd_stop = 1'b0;
        sta_clr = 1'b0;
        sm_vld = 1'b1;
        repeat (2) @(negedge clk_sys);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clr", 32'(para_clr), 32'd0);
        chk("rst_en", 32'(para_en), 32'd0);
        chk("rst_done", 32'(para_done), 32'd0);
        chk("rst_seq", 32'(win_seq), 32'd0);
        chk("rst_smp", 32'(smp_cnt), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        cmd_start = 1'b0;
        sm_vld = 1'b0;
        rst = 1'b0;

        // 1: single window of 4
        clr_cnt();
        step(1, 0, 0, 0);
        chk("t1_idle_clr", 32'(para_clr), 32'd0);
        step(0, 0, 0, 1);
        chk("t1_clr", 32'(para_clr), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_en_in_clr", 32'(para_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            chk("t1_en", 32'(para_en), 32'd1);
        end
        step(0, 0, 0, 1);
        chk("t1_done", 32'(para_done), 32'd1);
        chk("t1_smp", 32'(smp_cnt), 32'd4);
        step(0, 0, 0, 1);
        seq = 1;
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_seq", 32'(win_seq), 32'(seq));
        chk("t1_nclr", 32'(n_clr), 32'd1);
        chk("t1_nen", 32'(n_en), 32'd4);
        chk("t1_ndone", 32'(n_done), 32'd1);

        // 2: continuous, len 3, gap 2
        cfg_win_len = 16'd3;
        cfg_cont = 1'b1;
        cfg_gap = 8'd2;
        clr_cnt();
        step(1, 0, 0, 1);
        chk("t2_en_idle", 32'(para_en), 32'd0);
        for (int i = 0; i < 19; i++) begin
            step(0, 0, 0, 1);
            chk("t2_clr_pat", 32'(para_clr), 32'((i % 7) == 0));
            chk("t2_done_pat", 32'(para_done), 32'((i % 7) == 4));
            chk("t2_en_pat", 32'(para_en),
                32'((i % 7) >= 1 && (i % 7) <= 3));
        end
        seq += 3;
        step(0, 0, 0, 1);
        chk("t2_seq", 32'(win_seq), 32'(seq));
        step(0, 1, 0, 1);
        chk("t2_gap_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            chk("t2_stopped", 32'(busy), 32'd0);
        end
        chk("t2_nclr", 32'(n_clr), 32'd3);
        chk("t2_nen", 32'(n_en), 32'd9);
        chk("t2_ndone", 32'(n_done), 32'd3);

        // 3: length 0 acts as 1; abort mid-window
        cfg_win_len = 16'd0;
        cfg_cont = 1'b0;
        cfg_gap = 8'd0;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t3_clr", 32'(para_clr), 32'd1);
        step(0, 0, 0, 1);
        chk("t3_en", 32'(para_en), 32'd1);
        step(0, 0, 0, 0);
        chk("t3_done", 32'(para_done), 32'd1);
        chk("t3_smp1", 32'(smp_cnt), 32'd1);
        step(0, 0, 0, 0);
        seq += 1;
        chk("t3_idle", 32'(busy), 32'd0);
        chk("t3_seq", 32'(win_seq), 32'(seq));
        cfg_win_len = 16'd5;
        clr_cnt();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        chk("t3_run_busy", 32'(busy), 32'd1);
        chk("t3_smp_run", 32'(smp_cnt), 32'd2);
        step(0, 0, 0, 0);
        chk("t3_abort", 32'(busy), 32'd0);
        chk("t3_smp_hold", 32'(smp_cnt), 32'd2);
        chk("t3_seq_hold", 32'(win_seq), 32'(seq));
        chk("t3_nodone", 32'(n_done), 32'd0);

        // 4: stop on completing sample, then start+stop in IDLE
        cfg_win_len = 16'd4;
        cfg_cont = 1'b1;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        chk("t4_en_last", 32'(para_en), 32'd1);
        step(0, 0, 0, 0);
        chk("t4_done", 32'(para_done), 32'd1);
        step(0, 0, 0, 0);
        seq += 1;
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_seq", 32'(win_seq), 32'(seq));
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("t4_ss_busy", 32'(busy), 32'd0);
        chk("t4_ss_clr", 32'(para_clr), 32'd0);

        // 5: overrun flag, set-over-clear, sequence wrap
        cfg_win_len = 16'd2;
        cfg_cont = 1'b0;
        clr_cnt();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("t5_ovr_pre", 32'(ovr), 32'd0);
        chk("t5_en", 32'(para_en), 32'd1);
        step(0, 0, 0, 0);
        chk("t5_done", 32'(para_done), 32'd1);
        chk("t5_ovr", 32'(ovr), 32'd1);
        step(0, 0, 0, 0);
        seq += 1;
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_ovr_stick", 32'(ovr), 32'd1);
        chk("t5_nen", 32'(n_en), 32'd2);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("t5_ovr_clr", 32'(ovr), 32'd0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        step(0, 1, 0, 0);
        chk("t5_set_prio", 32'(ovr), 32'd1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("t5_ovr_clr2", 32'(ovr), 32'd0);
        chk("t5_seq_pre", 32'(win_seq), 32'(seq));
        cfg_win_len = 16'd1;
        cfg_cont = 1'b1;
        step(1, 0, 0, 0);
        for (int i = 0; i < 3 * (255 - seq); i++)
            step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        seq = 255;
        chk("t5_seq255", 32'(win_seq), 32'(seq));
        step(0, 0, 0, 0);
        chk("t5_idle255", 32'(busy), 32'd0);
        cfg_cont = 1'b0;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("t5_done_wrap", 32'(para_done), 32'd1);
        step(0, 0, 0, 0);
        chk("t5_wrap", 32'(win_seq), 32'd0);

        // 6: no samples for 16 RUN cycles
        cfg_win_len = 16'd4;
        clr_cnt();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0);
            chk("t6_run_busy", 32'(busy), 32'd1);
        end
        step(0, 0, 0, 0);
        chk("t6_nodone", 32'(n_done), 32'd0);
`ifdef PARA_SEQ_TMO_EN
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_tmo", 32'(tmo), 32'd1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("t6_tmo_clr", 32'(tmo), 32'd0);
`else
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_tmo", 32'(tmo), 32'd0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("t6_stop", 32'(busy), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
